// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter.
// Holds the writeback request and register-file write bundles.
package wb_arbiter_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } reg_file_in_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency writeback results.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign head = mem[rd_ptr];

    // Storage write, pointer advance and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results into one
// registered register-file write per cycle and tracks pending writes.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count;
    logic          empty;
    logic          push;
    logic          pop;
    logic          alu_take;
    wb_req_t       head;
    wb_req_t       push_data;
    wb_req_t       sel;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   busy_q;
    logic [31:0]   busy_d;
    reg_file_in_t  rf_q;

    assign empty     = (count == '0);
    assign ll_ready  = !rst && (count < CW'(DEPTH));
    assign push      = ll_valid && ll_ready;
    assign alu_stall = (wait_cnt == WW'(STARVE_MAX));
    assign pop       = !empty && (alu_stall || !alu_valid);
    assign alu_take  = alu_valid && !alu_stall;
    assign push_data = '{valid: 1'b1, rd: ll_rd, data: ll_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Pick this cycle's writeback source; pop and ALU take are exclusive.
    always_comb begin
        sel = '0;
        unique case (1'b1)
            pop:      sel = head;
            alu_take: sel = '{valid: 1'b1, rd: alu_rd, data: alu_data};
            default:  sel = '0;
        endcase
    end

    // Register the selected result; writes to x0 are suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '0;
        end else begin
            rf_q.we <= sel.valid && (sel.rd != REG_ZERO);
            if (sel.valid) begin
                rf_q.waddr <= sel.rd;
                rf_q.wdata <= sel.data;
            end
        end
    end

    // Count cycles the FIFO head waits behind the ALU.
    always_ff @(posedge clk) begin
        if (rst || empty || pop) begin
            wait_cnt <= '0;
        end else if (!alu_stall) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Scoreboard update; a same-edge issue beats the retiring pop.
    always_comb begin
        busy_d = busy_q;
        if (pop && head.rd != REG_ZERO) begin
            busy_d[head.rd] = 1'b0;
        end
        if (issue_valid && issue_rd != REG_ZERO) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending long-latency write bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rf_we    = rf_q.we;
    assign rf_waddr = rf_q.waddr;
    assign rf_wdata = rf_q.wdata;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and scoreboard that drives the register file's write port. It merges single-cycle ALU results with long-latency results (load, mul/div) buffered in a small FIFO, and presents one registered write per cycle. It tracks which architectural registers have long-latency writes outstanding so decode can stall on hazards. It sits between the execute/memory stages and `RegisterFile`.

## Interface
- `DEPTH`, 2: long-latency FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 4: blocked cycles the FIFO head tolerates before the ALU is stalled (≥1).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present; no backpressure.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  32  ALU result.
- `alu_stall`  out  1  upstream must hold `alu_valid`=0 this cycle.
- `ll_valid`  in  1  long-latency result offered.
- `ll_ready`  out  1  FIFO can accept; push = `ll_valid & ll_ready`.
- `ll_rd`  in  5  long-latency destination.
- `ll_data`  in  32  long-latency result.
- `issue_valid`  in  1  long-latency op issued this cycle.
- `issue_rd`  in  5  its destination.
- `busy`  out  32  per-register pending long-latency write; bit 0 always 0.
- `rf_we`  out  1  to `RegisterFileIn.we`.
- `rf_waddr`  out  5  to `RegisterFileIn.waddr`.
- `rf_wdata`  out  32  to `RegisterFileIn.wdata`.

## Operation
- Selection each cycle, in priority order:
  - If `alu_stall`=1 and the FIFO is non-empty, pop the head.
  - Otherwise, if `alu_valid`, take the ALU result.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise, idle.
- Selected result registers into `rf_we/rf_waddr/rf_wdata` on the next edge. If the selected rd=0, `rf_we`=0 but a FIFO pop still occurs.
- `alu_valid`=1 while `alu_stall`=1 is a protocol error: the result is dropped; the bench asserts this never happens.
- FIFO:
  - `ll_ready` = count<DEPTH, from registered count only.
  - Push and pop in the same cycle are legal; count is unchanged. A push when full is impossible.
  - Pointers wrap modulo DEPTH.
- Starvation counter `wait`, width clog2(STARVE_MAX+1):
  - Increments (saturating at STARVE_MAX) in each cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
  - `alu_stall` = (`wait`==STARVE_MAX), combinational from the register.
- Scoreboard:
  - `issue_valid` with `issue_rd`≠0 sets `busy[issue_rd]`.
  - A FIFO pop with rd≠0 clears `busy[rd]` on the same edge that loads `rf_we`.
  - If set and clear hit the same bit on the same edge, set wins: a newer op is pending.
  - ALU writes never touch `busy`.
- Reset:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, FIFO empty, `wait`=0, `alu_stall`=0.
  - `ll_ready`=0 while `rst`=1, and 1 from the first cycle after reset.
  - Reset mid-operation discards queued entries and busy bits; upstream flushes in the same cycle.

## Timing
- ALU result in cycle N → `rf_we` high in N+1, so the register file commits at the end of N+1.
- LL push in cycle N → head visible in N+1 → if popped in N+1, `rf_we` high in N+2 and `busy` bit low in N+2. The register file's write bypass makes reads in N+2 see the data.
- `alu_stall` rises in the cycle after the STARVE_MAX-th blocked cycle and drops the cycle after the pop.
- `ll_ready` reacts to a pop one cycle later, since it is computed from the registered count.
- Throughput: one write per cycle; the ALU can delay the FIFO head by at most STARVE_MAX cycles.

## Structure
- `Bundle` package additions:
  - typedef `WbReq` {valid, rd[4:0], data[31:0]}.
  - Constant `REG_ZERO` = 5'd0.
  - The top-level packs `rf_we/rf_waddr/rf_wdata` into `Bundle::RegisterFileIn`.
- One sub-module, `wb_fifo`: parameterised by DEPTH, element type `WbReq`, with push/pop/count/head outputs. Starvation counter, selection mux, scoreboard and output registers stay in `wb_arbiter`.

## Test plan
- Reset: hold `rst` for 2 cycles with all inputs active → all outputs 0 and `ll_ready`=0 during reset; `ll_ready`=1 in the first cycle after reset.
- ALU only: `alu_valid`, rd=5, data=0xDEADBEEF in cycle 3 → `rf_we`=1, `waddr`=5, `wdata`=0xDEADBEEF in cycle 4. Same stimulus with rd=0 → `rf_we`=0.
- LL with scoreboard: issue rd=7 in cycle 1 → `busy[7]`=1 from cycle 2. Push rd=7, data=0x1234 in cycle 5 with the ALU idle → `rf_we`, waddr=7 and `busy[7]`=0 in cycle 7.
- Starvation (STARVE_MAX=4): push in cycle 0; `alu_valid` held 1 until `alu_stall` is seen → `alu_stall`=1 in cycle 5; LL write in cycle 6; `alu_stall`=0 in cycle 6.
- FIFO full and wrap: push 3 entries back-to-back with the ALU busy → `ll_ready`=0 after 2 pushes. Then drain and refill 4 times → writes emerge in push order, with no loss or duplication.
- Set/clear collision: pop for rd=9 and `issue_rd`=9 in the same cycle → `busy[9]` stays 1.
